apb_reg_bank: RTL

Parametrised APB slave register bank: the successor to the fixed 16x32 zero-wait register file. It adds configurable data width and depth, programmable wait states, address/permission error reporting, per-register read-only masking, and a synchronous reset value. It exports every register and a per-register write strobe to the fabric. It sits behind the APB interconnect as a generic control/status register target.

---
 rtl/apb_reg_bank.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/apb_reg_bank.sv
// Parametrised APB slave register bank with wait states, error reporting and read-only masking.
// Optional APB_REG_BANK_PSTRB_EN: byte strobes qualify writes; otherwise every write updates the full word.

module apb_reg_bank_slot #(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] byte_en,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   q
);
    always_ff @(posedge CLK) begin
        if (RESET) begin
            q <= RESET_VALUE;
        end else if (we) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (byte_en[b]) q[8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end
endmodule

module apb_reg_bank #(
    parameter int                           DATA_WIDTH   = 32,
    parameter int                           REG_NUM_BITS = 4,
    parameter int                           WAIT_CYCLES  = 0,
    parameter logic [2**REG_NUM_BITS-1:0]   RO_MASK      = '0,
    parameter logic [DATA_WIDTH-1:0]        RESET_VALUE  = '0
) (
    input  logic                                   CLK,
    input  logic                                   RESET,
    input  logic                                   i_psel,
    input  logic                                   i_penable,
    input  logic                                   i_pwrite,
    input  logic [31:0]                            i_paddr,
    input  logic [DATA_WIDTH-1:0]                  i_pwdata,
    input  logic [DATA_WIDTH/8-1:0]                i_pstrb,
    output logic [DATA_WIDTH-1:0]                  o_prdata,
    output logic                                   o_pready,
    output logic                                   o_pslverr,
    output logic [(2**REG_NUM_BITS)*DATA_WIDTH-1:0] o_regs,
    output logic [2**REG_NUM_BITS-1:0]             o_wr_stb
);
    localparam int NREG = 2**REG_NUM_BITS;
    localparam int NB   = DATA_WIDTH/8;
    localparam int AL   = $clog2(NB);
    localparam logic [31:0] ALIGN_MASK = 32'((64'(1) << AL) - 64'(1));

    typedef enum logic {S_IDLE, S_ACCESS} state_t;

    state_t                            state_q, state_d;
    logic [3:0]                        wcnt_q, wcnt_d;
    logic                              done;
    logic [REG_NUM_BITS-1:0]           idx;
    logic                              misaligned, out_of_range, err, we;
    logic [NB-1:0]                     byte_en;
    logic [NREG-1:0][DATA_WIDTH-1:0]   regs;
    logic [NREG-1:0]                   wr_stb_q;

    assign idx          = i_paddr[AL +: REG_NUM_BITS];
    assign misaligned   = |(i_paddr & ALIGN_MASK);
    assign out_of_range = |(i_paddr >> (REG_NUM_BITS + AL));
    assign err          = misaligned | out_of_range | (i_pwrite & RO_MASK[idx]);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_psel && !i_penable) begin
                    state_d = S_ACCESS;
                    wcnt_d  = 4'(WAIT_CYCLES);
                end
            end
            S_ACCESS: begin
                // Losing psel mid-access abandons the transfer without side effects.
                if (!i_psel) begin
                    state_d = S_IDLE;
                end else if (i_penable) begin
                    if (wcnt_q != 4'd0) begin
                        wcnt_d = wcnt_q - 4'd1;
                    end else begin
                        done    = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_pready  = done & ~RESET;
    assign o_pslverr = o_pready & err;
    assign o_prdata  = (o_pready && !i_pwrite && !err) ? regs[idx] : '0;
    assign we        = o_pready & i_pwrite & ~err;

`ifdef APB_REG_BANK_PSTRB_EN
    assign byte_en = i_pstrb;
`else
    logic unused_pstrb;
    assign byte_en      = '1;
    assign unused_pstrb = ^i_pstrb;
`endif

    for (genvar i = 0; i < NREG; i++) begin : g_reg
        apb_reg_bank_slot #(
            .DATA_WIDTH  (DATA_WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_slot (
            .CLK     (CLK),
            .RESET   (RESET),
            .we      (we && (idx == REG_NUM_BITS'(i))),
            .byte_en (byte_en),
            .wdata   (i_pwdata),
            .q       (regs[i])
        );
    end

    // Strobe is registered so it lines up with the updated o_regs value.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_stb_q <= '0;
        end else begin
            wr_stb_q <= '0;
            if (we) wr_stb_q[idx] <= 1'b1;
        end
    end

    assign o_regs   = regs;
    assign o_wr_stb = wr_stb_q;
endmodule
